cam_clk_seq: RTL and testbench
==============================

CAM_CLK_SEQ -- requirements
Module: cam_clk_seq

Interface
REQ-001 SHALL have parameter FI, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter FS, default 24000000, default camera clock frequency in Hz; DIV_DEFAULT = FI/FS, integer division.
REQ-003 SHALL have parameter T_SETTLE, default 1000, clock cycles xclk runs before power-down release.
REQ-004 SHALL have parameter T_RST, default 1000, cycles cam_rst_n is held low after power-down release.
REQ-005 SHALL have parameter T_READY, default 20000, cycles from cam_rst_n release to ready.
REQ-006 SHALL have port clk, input, 1, single system clock; all logic on its posedge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1, level request to power the camera up (1) or down (0).
REQ-009 SHALL have port div_req, input, 1, one-cycle request to change the divider.
REQ-010 SHALL have port div_val, input, 8, new half-period reload value, sampled with div_req.
REQ-011 SHALL have port div_ack, output, 1, one-cycle pulse when the new value takes effect.
REQ-012 SHALL have port xclk, output, 1, generated camera clock.
REQ-013 SHALL have ports cam_pwdn (output, 1, active-high camera power-down) and cam_rst_n (output, 1, active-low camera reset).
REQ-014 SHALL have ports ready (output, 1, camera usable) and led (output, 1, status; equals ready).

Function
REQ-015 Divider SHALL hold an 8-bit reload value div_cur and a down-counter; xclk toggles when the counter is 0, which then reloads div_cur, so each half-period is div_cur+1 clk cycles; div_cur=0 gives clk/2.
REQ-016 The FSM SHALL have states OFF, CLK_ON, PWRUP, RELEASE, RUN, STOP.
REQ-017 OFF: xclk=0, counter=div_cur, cam_pwdn=1, cam_rst_n=0, ready=0; enable=1 at a clock edge moves to CLK_ON on that edge.
REQ-018 CLK_ON: divider runs, cam_pwdn=1, cam_rst_n=0; after T_SETTLE cycles -> PWRUP.
REQ-019 PWRUP: cam_pwdn=0, cam_rst_n=0; after T_RST cycles -> RELEASE.
REQ-020 RELEASE: cam_pwdn=0, cam_rst_n=1; after T_READY cycles -> RUN.
REQ-021 RUN: ready=1, registered, so ready rises in the first RUN cycle; stays until enable=0.
REQ-022 enable=0 in CLK_ON, PWRUP, RELEASE or RUN SHALL go to STOP on the next edge: ready=0, cam_rst_n=0, cam_pwdn=1 immediately.
REQ-023 STOP: the divider keeps running until xclk is 0 at a counter reload, then stops with xclk=0 and -> OFF; xclk never produces a shortened high phase.
REQ-024 enable=1 during STOP SHALL be ignored until OFF is reached.
REQ-025 State timers SHALL be 16 bits; T_* values of 0 SHALL be treated as 1.
REQ-026 div_req SHALL capture div_val into a pending register and set pending.
REQ-027 While xclk runs, pending SHALL be applied at the counter reload that drives xclk 1->0: that reload uses the new value, div_cur updates, and div_ack pulses in the same cycle.
REQ-028 In OFF, pending SHALL be applied on the next edge and div_ack pulsed.
REQ-029 A div_req while pending SHALL overwrite the pending value; one div_ack only.
REQ-030 A div_req coinciding with an apply event SHALL apply the old pending value, ack it, and keep the new request pending.

Reset
REQ-031 reset=0 SHALL immediately force state OFF, xclk=0, cam_pwdn=1, cam_rst_n=0, ready=0, led=0, div_ack=0, pending=0, div_cur=DIV_DEFAULT, timers=0, including mid-sequence and mid-xclk-high.
REQ-032 After reset release, the first action SHALL occur at the first posedge sampling enable=1.

Configuration
REQ-033 With CAM_CLK_DIV_RUNTIME_EN defined, REQ-026..REQ-030 apply.
REQ-034 Without CAM_CLK_DIV_RUNTIME_EN, div_req and div_val SHALL be ignored, div_ack tied 0, and div_cur constant DIV_DEFAULT; the ports remain present.

Verification
REQ-035 Defaults (DIV_DEFAULT=2) with T_SETTLE=4, T_RST=3, T_READY=5; enable high at edge k -> xclk period 6 clk; cam_pwdn falls at k+5; cam_rst_n rises at k+8; ready and led rise at k+13.
REQ-036 In RUN, pulse div_req with div_val=0 -> div_ack at the next xclk 1->0 reload; xclk period then 2 clk; with the macro undefined, period stays 6 and div_ack stays 0.
REQ-037 In RUN, drop enable during xclk high -> ready=0 and cam_rst_n=0 the next cycle; the high phase completes at full 3 cycles; xclk then stays 0 and the FSM reaches OFF.
REQ-038 Pulse div_req with div_val=5, then div_val=7 before the apply point -> one div_ack, half-period 8 clk.
REQ-039 Assert reset=0 asynchronously in PWRUP while xclk=1 -> all outputs reach reset values before the next clock edge; re-enabling repeats the full REQ-035 timing.
REQ-040 In OFF, div_req with div_val=9 -> div_ack next cycle; a later enable gives a 20-clk xclk period.

Source files
------------

// File: rtl/cam_clk_seq_if.sv
// cam_clk_seq_if: power-sequencing request, divider update and camera-side signals of cam_clk_seq.
interface cam_clk_seq_if;
    logic       enable;
    logic       div_req;
    logic [7:0] div_val;
    logic       div_ack;
    logic       xclk;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       ready;
    logic       led;
    modport slave (
        input  enable, div_req, div_val,
        output div_ack, xclk, cam_pwdn, cam_rst_n, ready, led
    );
    modport master (
        output enable, div_req, div_val,
        input  div_ack, xclk, cam_pwdn, cam_rst_n, ready, led
    );
endinterface

// File: rtl/cam_clk_seq.sv
// cam_clk_seq: camera clock divider plus power-up/down sequencer (xclk, cam_pwdn, cam_rst_n, ready).
// Runtime divider updates exist only when CAM_CLK_DIV_RUNTIME_EN is defined.
module cam_clk_seq #(
    parameter int unsigned FI       = 50000000,
    parameter int unsigned FS       = 24000000,
    parameter int unsigned T_SETTLE = 1000,
    parameter int unsigned T_RST    = 1000,
    parameter int unsigned T_READY  = 20000
) (
    input logic          clk,
    input logic          reset,
    cam_clk_seq_if.slave bus
);
    localparam logic [7:0]  DIV_DEFAULT = 8'(FI / FS);
    localparam logic [15:0] LIM_SETTLE  = (T_SETTLE == 0) ? 16'd1 : 16'(T_SETTLE);
    localparam logic [15:0] LIM_RST     = (T_RST == 0) ? 16'd1 : 16'(T_RST);
    localparam logic [15:0] LIM_READY   = (T_READY == 0) ? 16'd1 : 16'(T_READY);

    typedef enum logic [2:0] {OFF, CLK_ON, PWRUP, RELEASE, RUN, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] tmr_q, tmr_d, lim;
    logic [7:0]  cnt_q, cnt_d, div_cur_q, div_cur_d, new_div;
    logic        xclk_q, xclk_d, pwdn_q, pwdn_d, rst_n_q, rst_n_d;
    logic        ready_q, ready_d, ack_q, ack_d;
    logic        fall, apply, done;

    // the reload that ends a high phase is the only safe point to change the period
    assign fall = (state_q != OFF) && (cnt_q == 8'd0) && xclk_q;

`ifdef CAM_CLK_DIV_RUNTIME_EN
    logic       pend_q, pend_d;
    logic [7:0] pval_q, pval_d;
    assign apply   = pend_q && ((state_q == OFF) || fall);
    assign new_div = pval_q;
    always_comb begin
        pend_d = bus.div_req || (pend_q && !apply);
        pval_d = bus.div_req ? bus.div_val : pval_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
            pval_q <= DIV_DEFAULT;
        end else begin
            pend_q <= pend_d;
            pval_q <= pval_d;
        end
    end
`else
    assign apply   = 1'b0;
    assign new_div = DIV_DEFAULT;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= OFF;
            tmr_q     <= '0;
            cnt_q     <= DIV_DEFAULT;
            div_cur_q <= DIV_DEFAULT;
            xclk_q    <= 1'b0;
            pwdn_q    <= 1'b1;
            rst_n_q   <= 1'b0;
            ready_q   <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            div_cur_q <= div_cur_d;
            xclk_q    <= xclk_d;
            pwdn_q    <= pwdn_d;
            rst_n_q   <= rst_n_d;
            ready_q   <= ready_d;
            ack_q     <= ack_d;
        end
    end

    assign lim  = (state_q == CLK_ON) ? LIM_SETTLE : (state_q == PWRUP) ? LIM_RST : LIM_READY;
    assign done = (tmr_q == lim - 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF:     state_d = bus.enable ? CLK_ON : OFF;
            CLK_ON:  state_d = !bus.enable ? STOP : done ? PWRUP : CLK_ON;
            PWRUP:   state_d = !bus.enable ? STOP : done ? RELEASE : PWRUP;
            RELEASE: state_d = !bus.enable ? STOP : done ? RUN : RELEASE;
            RUN:     state_d = !bus.enable ? STOP : RUN;
            STOP:    state_d = ((cnt_q == 8'd0) && !xclk_q) ? OFF : STOP;
            default: state_d = OFF;
        endcase
        tmr_d = ((state_d != state_q) || (state_q inside {OFF, RUN, STOP})) ? 16'd0 : tmr_q + 16'd1;
    end

    // STOP never starts a new high phase: a low-phase reload parks xclk at 0
    always_comb begin
        div_cur_d = apply ? new_div : div_cur_q;
        cnt_d     = (state_q == OFF || cnt_q == 8'd0) ? div_cur_d : cnt_q - 8'd1;
        xclk_d    = xclk_q;
        if (state_q == OFF)
            xclk_d = 1'b0;
        else if (cnt_q == 8'd0)
            xclk_d = (state_q == STOP) ? 1'b0 : !xclk_q;
    end

    always_comb begin
        pwdn_d  = !(state_d inside {PWRUP, RELEASE, RUN});
        rst_n_d = state_d inside {RELEASE, RUN};
        ready_d = (state_d == RUN);
        ack_d   = apply;
    end

    assign bus.xclk      = xclk_q;
    assign bus.cam_pwdn  = pwdn_q;
    assign bus.cam_rst_n = rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.led       = ready_q;
    assign bus.div_ack   = ack_q;
endmodule

// File: tb/tb_cam_clk_seq.sv
// tb_cam_clk_seq: directed checks of power sequencing, xclk timing, stop, async reset and divider updates.
module tb_cam_clk_seq;
    localparam int T_SETTLE = 4;
    localparam int T_RST    = 3;
    localparam int T_READY  = 5;
`ifdef CAM_CLK_DIV_RUNTIME_EN
    localparam bit RT = 1'b1;
`else
    localparam bit RT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    cam_clk_seq_if bus ();

    cam_clk_seq #(
        .FI(50000000), .FS(24000000),
        .T_SETTLE(T_SETTLE), .T_RST(T_RST), .T_READY(T_READY)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_xclk(input logic v, output int n);
        n = 0;
        while (bus.xclk !== v && n < 300) begin
            step(1);
            n++;
        end
    endtask

    task automatic measure(output int hi, output int per);
        int n, lo;
        wait_xclk(1'b0, n);
        wait_xclk(1'b1, n);
        wait_xclk(1'b0, hi);
        wait_xclk(1'b1, lo);
        per = hi + lo;
    endtask

    task automatic watch(input int n, output int acks, output int on_fall);
        logic px;
        acks = 0;
        on_fall = 0;
        px = bus.xclk;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (bus.div_ack === 1'b1) begin
                acks++;
                if (px && !bus.xclk) on_fall++;
            end
            px = bus.xclk;
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_xclk"}, bus.xclk, 0);
        check({p, "_pwdn"}, bus.cam_pwdn, 1);
        check({p, "_rst_n"}, bus.cam_rst_n, 0);
        check({p, "_ready"}, bus.ready, 0);
        check({p, "_led"}, bus.led, 0);
        check({p, "_ack"}, bus.div_ack, 0);
    endtask

    // enable is driven just after edge k; cycle c is sampled just after edge k+c
    task automatic power_up_check(input string p);
        int f_pwdn, f_rst, f_rdy, f_led, f_xclk, hi, per;
        f_pwdn = 0; f_rst = 0; f_rdy = 0; f_led = 0; f_xclk = 0;
        bus.enable = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step(1);
            if (f_pwdn == 0 && bus.cam_pwdn === 1'b0) f_pwdn = c;
            if (f_rst == 0 && bus.cam_rst_n === 1'b1) f_rst = c;
            if (f_rdy == 0 && bus.ready === 1'b1) f_rdy = c;
            if (f_led == 0 && bus.led === 1'b1) f_led = c;
            if (f_xclk == 0 && bus.xclk === 1'b1) f_xclk = c;
        end
        check({p, "_pwdn_fall"}, f_pwdn, 5);
        check({p, "_rst_rise"}, f_rst, 8);
        check({p, "_ready_rise"}, f_rdy, 13);
        check({p, "_led_rise"}, f_led, 13);
        check({p, "_xclk_rise"}, f_xclk, 4);
        measure(hi, per);
        check({p, "_xclk_hi"}, hi, 3);
        check({p, "_xclk_per"}, per, 6);
    endtask

    initial begin
        int n, hi, per, acks, on_fall, seen, found;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.div_req = 1'b0;
        bus.div_val = 8'd0;
        step(3);
        check_reset("rst");
        reset = 1'b1;
        step(3);
        check("idle_pwdn", bus.cam_pwdn, 1);
        check("idle_xclk", bus.xclk, 0);

        power_up_check("boot");

        // drop enable in the first high cycle of xclk
        wait_xclk(1'b0, n);
        wait_xclk(1'b1, n);
        bus.enable = 1'b0;
        step(1);
        check("stop_ready", bus.ready, 0);
        check("stop_rst_n", bus.cam_rst_n, 0);
        check("stop_pwdn", bus.cam_pwdn, 1);
        check("stop_xclk_still_hi", bus.xclk, 1);
        wait_xclk(1'b0, n);
        check("stop_hi_len", n + 1, 3);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.xclk !== 1'b0) seen = 1;
        end
        check("stop_xclk_parked", seen, 0);

        // divider update while OFF
        bus.div_req = 1'b1;
        bus.div_val = 8'd9;
        step(1);
        bus.div_req = 1'b0;
        check("off_ack_capture", bus.div_ack, 0);
        step(1);
        check("off_ack", bus.div_ack, RT ? 1 : 0);
        step(1);
        check("off_ack_pulse", bus.div_ack, 0);
        bus.enable = 1'b1;
        measure(hi, per);
        check("div9_hi", hi, RT ? 10 : 3);
        check("div9_per", per, RT ? 20 : 6);
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        check("run_ready", bus.ready, 1);

        // two requests before the apply point collapse into one update
        wait_xclk(1'b1, n);
        wait_xclk(1'b0, n);
        bus.div_req = 1'b1;
        bus.div_val = 8'd5;
        step(1);
        bus.div_req = 1'b0;
        step(1);
        bus.div_req = 1'b1;
        bus.div_val = 8'd7;
        step(1);
        bus.div_req = 1'b0;
        watch(40, acks, on_fall);
        check("ovw_acks", acks, RT ? 1 : 0);
        check("ovw_on_fall", on_fall, RT ? 1 : 0);
        measure(hi, per);
        check("div7_hi", hi, RT ? 8 : 3);
        check("div7_per", per, RT ? 16 : 6);

        // fastest divider in RUN
        bus.div_req = 1'b1;
        bus.div_val = 8'd0;
        step(1);
        bus.div_req = 1'b0;
        watch(30, acks, on_fall);
        check("div0_acks", acks, RT ? 1 : 0);
        check("div0_on_fall", on_fall, RT ? 1 : 0);
        measure(hi, per);
        check("div0_hi", hi, RT ? 1 : 3);
        check("div0_per", per, RT ? 2 : 6);
        check("div0_ready", bus.ready, 1);

        // async reset in PWRUP while xclk is high
        bus.enable = 1'b0;
        step(60);
        check("off2_xclk", bus.xclk, 0);
        check("off2_pwdn", bus.cam_pwdn, 1);
        bus.enable = 1'b1;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (bus.cam_pwdn === 1'b0 && bus.xclk === 1'b1) begin
                found = 1;
                break;
            end
        end
        check("pwrup_xclk_hi", found, 1);
        #2 reset = 1'b0;
        #1 check_reset("async");
        bus.enable = 1'b0;
        #3 reset = 1'b1;
        step(2);
        check_reset("post_rst");
        power_up_check("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
